// File: rtl/muldiv_unit_pkg.sv
// Shared constants, state encoding and op-decode helpers for the RV32M multiply/divide unit.
// Op codes mirror the ALU control decoder encodings; the M-ops occupy a contiguous range.
// No logic lives here beyond small pure decode functions.
package muldiv_unit_pkg;

  localparam int MD_XLEN = 32;

  // ALU control decoder op codes (only ADD and the M-ops are of interest here)
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  function automatic logic is_mop(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_REMU);
  endfunction

  function automatic logic is_divop(input logic [4:0] sel);
    return (sel >= ALU_DIV) && (sel <= ALU_REMU);
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic rs1_signed(input logic [4:0] sel);
    return (sel == ALU_MUL) || (sel == ALU_MULH) || (sel == ALU_MULHSU) ||
           (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic rs2_signed(input logic [4:0] sel);
    return (sel == ALU_MUL) || (sel == ALU_MULH) ||
           (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Restores the sign of a magnitude result: returns -mag when neg is set, else mag.
// Purely combinational, zero latency.
// No handshake; output follows inputs.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mag_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] val_o
);

  // Two's-complement negate when the true result is negative
  always_comb begin
    val_o = neg_i ? (-mag_i) : mag_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execution unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Latency: ITER+1 cycles from accept to done for normal ops, 1 cycle for divide special cases.
// busy is held through the iterations so the hazard unit stalls EX; start is ignored unless idle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN,
  parameter int ITER = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [4:0]      alu_sel_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  ALL_ONES = '1;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              is_rem_q, is_rem_d;
  logic              hi_q, hi_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [XLEN-1:0]   opb_q, opb_d;       // multiplier (shifted right) or divisor
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   quot_q, quot_d;     // dividend shifts out of the top, quotient bits in at the bottom
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Accept-time decode of the incoming op
  logic              s1, s2;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;

  // Divide step: shift one dividend bit into the partial remainder and trial-subtract
  logic [XLEN:0]     rem_shift, rem_diff;

  // Sign-corrected results
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   div_mag, div_fixed;

  muldiv_sign_fix #(.WIDTH(2*XLEN)) u_fix_prod (
    .mag_i (prod_q),
    .neg_i (neg_q),
    .val_o (prod_fixed)
  );

  muldiv_sign_fix #(.WIDTH(XLEN)) u_fix_div (
    .mag_i (div_mag),
    .neg_i (neg_q),
    .val_o (div_fixed)
  );

  // Operand sign/magnitude extraction and divide special-case detection
  always_comb begin
    s1       = rs1_signed(alu_sel_i) && rs1_val_i[XLEN-1];
    s2       = rs2_signed(alu_sel_i) && rs2_val_i[XLEN-1];
    mag_a    = s1 ? (-rs1_val_i) : rs1_val_i;
    mag_b    = s2 ? (-rs2_val_i) : rs2_val_i;
    div_zero = is_divop(alu_sel_i) && (rs2_val_i == '0);
    div_ovf  = ((alu_sel_i == ALU_DIV) || (alu_sel_i == ALU_REM)) &&
               (rs1_val_i == MIN_NEG) && (rs2_val_i == ALL_ONES);
  end

  // Restoring-divide datapath; the top bit of the difference is the borrow
  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, opb_q};
    div_mag   = is_rem_q ? rem_q : quot_q;
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    is_rem_d   = is_rem_q;
    hi_d       = hi_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    prod_d     = prod_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    result_d   = result_q;
    done_d     = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (!flush_i && start_i && is_mop(alu_sel_i)) begin
          is_div_d   = is_divop(alu_sel_i);
          is_rem_d   = (alu_sel_i == ALU_REM) || (alu_sel_i == ALU_REMU);
          hi_d       = (alu_sel_i == ALU_MULH) || (alu_sel_i == ALU_MULHSU) ||
                       (alu_sel_i == ALU_MULHU);
          // remainder takes the dividend's sign, everything else the xor
          neg_d      = is_rem_d ? s1 : (s1 ^ s2);
          mcand_d    = {{XLEN{1'b0}}, mag_a};
          opb_d      = mag_b;
          prod_d     = '0;
          quot_d     = mag_a;
          rem_d      = '0;
          cnt_d      = '0;
          spec_d     = div_zero || div_ovf;
          if (div_zero) begin
            spec_res_d = is_rem_d ? rs1_val_i : ALL_ONES;
          end else begin
            spec_res_d = is_rem_d ? '0 : MIN_NEG;
          end
          state_d    = spec_d ? MD_FINISH : MD_CALC;
        end
      end

      MD_CALC: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          if (is_div_q) begin
            if (!rem_diff[XLEN]) begin
              rem_d  = rem_diff[XLEN-1:0];
              quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
              rem_d  = rem_shift[XLEN-1:0];
              quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
          end else begin
            if (opb_q[0]) begin
              prod_d = prod_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = MD_FINISH;
          end
        end
      end

      MD_FINISH: begin
        state_d = MD_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (spec_q) begin
            result_d = spec_res_q;
          end else if (is_div_q) begin
            result_d = div_fixed;
          end else if (hi_q) begin
            result_d = prod_fixed[2*XLEN-1:XLEN];
          end else begin
            result_d = prod_fixed[XLEN-1:0];
          end
        end
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase

    busy_d = (state_d == MD_CALC);
  end

  // State and datapath registers; reset abandons any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      is_rem_q   <= 1'b0;
      hi_q       <= 1'b0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      prod_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      is_rem_q   <= is_rem_d;
      hi_q       <= hi_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      prod_q     <= prod_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
